// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB plus 2-bit saturating PHT, registered prediction.
// Optional gshare indexing of the PHT is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
  parameter int BTB_ENTRIES = 32,
  parameter int TAG_W       = 10,
  parameter int PHT_ENTRIES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic        fetch_stall,
  input  logic        fetch_flush,
  input  logic [31:0] fetch_pc,
  output logic        pre_valid,
  output logic [31:0] pre_pc,
  output logic        pre_is_branch_taken,
  output logic [31:0] pre_branch_addr,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        taken_or_not_actual,
  input  logic [31:0] branch_actual_addr
);
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int PW = $clog2(PHT_ENTRIES);

  logic             r_btb_valid [BTB_ENTRIES];
  logic [TAG_W-1:0] r_btb_tag   [BTB_ENTRIES];
  logic [31:0]      r_btb_tgt   [BTB_ENTRIES];
  logic [1:0]       r_pht       [PHT_ENTRIES];

  logic             r_pre_valid_p1;
  logic [31:0]      r_pre_pc_p1;
  logic             r_pre_taken_p1;
  logic [31:0]      r_pre_addr_p1;

  logic [IW-1:0]    w_f_bidx, w_u_bidx;
  logic [TAG_W-1:0] w_f_tag, w_u_tag;
  logic [PW-1:0]    w_f_pidx, w_u_pidx;
  logic             w_f_hit, w_f_taken;
  logic [31:0]      w_f_addr;
  logic             w_unused;

  function automatic logic [1:0] f_sat_cnt(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  assign w_f_bidx = fetch_pc[IW+1:2];
  assign w_f_tag  = fetch_pc[IW+TAG_W+1:IW+2];
  assign w_u_bidx = update_pc[IW+1:2];
  assign w_u_tag  = update_pc[IW+TAG_W+1:IW+2];
  assign w_unused = ^{update_pc[31:IW+TAG_W+2], update_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [PW-1:0] r_ghr;

  // History is non-speculative: it advances only on resolved updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_ghr <= '0;
    else if (update_en) r_ghr <= {r_ghr[PW-2:0], taken_or_not_actual};
  end

  assign w_f_pidx = fetch_pc[PW+1:2] ^ r_ghr;
  assign w_u_pidx = update_pc[PW+1:2] ^ r_ghr;
`else
  assign w_f_pidx = fetch_pc[PW+1:2];
  assign w_u_pidx = update_pc[PW+1:2];
`endif

  // Stage p0: combinational lookup on the pre-update table contents.
  assign w_f_hit   = r_btb_valid[w_f_bidx] && (r_btb_tag[w_f_bidx] == w_f_tag);
  assign w_f_taken = w_f_hit && r_pht[w_f_pidx][1];
  assign w_f_addr  = w_f_taken ? r_btb_tgt[w_f_bidx] : fetch_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_btb_valid[i] <= 1'b0;
      for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= 2'b01;
    end else if (update_en) begin
      r_pht[w_u_pidx] <= f_sat_cnt(r_pht[w_u_pidx], taken_or_not_actual);
      if (taken_or_not_actual) r_btb_valid[w_u_bidx] <= 1'b1;
    end
  end

  // A taken update either refreshes a hit or allocates over the old occupant.
  always_ff @(posedge clk) begin
    if (update_en && taken_or_not_actual) begin
      r_btb_tag[w_u_bidx] <= w_u_tag;
      r_btb_tgt[w_u_bidx] <= branch_actual_addr;
    end
  end

  // Stage p1: prediction register; flush beats stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_valid_p1 <= 1'b0;
      r_pre_pc_p1    <= '0;
      r_pre_taken_p1 <= 1'b0;
      r_pre_addr_p1  <= '0;
    end else if (fetch_flush) begin
      r_pre_valid_p1 <= 1'b0;
    end else if (!fetch_stall) begin
      r_pre_valid_p1 <= fetch_valid;
      r_pre_pc_p1    <= fetch_pc;
      r_pre_taken_p1 <= w_f_taken;
      r_pre_addr_p1  <= w_f_addr;
    end
  end

  assign pre_valid           = r_pre_valid_p1;
  assign pre_pc              = r_pre_pc_p1;
  assign pre_is_branch_taken = r_pre_taken_p1;
  assign pre_branch_addr     = r_pre_addr_p1;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a behavioural table model predicts each registered output.
module tb_branch_predictor;
  localparam int BTB = 32;
  localparam int TW  = 10;
  localparam int PHT = 256;
  localparam int IW  = $clog2(BTB);

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fetch_valid = 0, fetch_stall = 0, fetch_flush = 0;
  logic [31:0] fetch_pc = '0;
  logic        pre_valid, pre_is_branch_taken;
  logic [31:0] pre_pc, pre_branch_addr;
  logic        update_en = 0, taken_or_not_actual = 0;
  logic [31:0] update_pc = '0, branch_actual_addr = '0;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(.BTB_ENTRIES(BTB), .TAG_W(TW), .PHT_ENTRIES(PHT)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_stall(fetch_stall), .fetch_flush(fetch_flush),
    .fetch_pc(fetch_pc),
    .pre_valid(pre_valid), .pre_pc(pre_pc),
    .pre_is_branch_taken(pre_is_branch_taken), .pre_branch_addr(pre_branch_addr),
    .update_en(update_en), .update_pc(update_pc),
    .taken_or_not_actual(taken_or_not_actual), .branch_actual_addr(branch_actual_addr)
  );

  typedef struct packed {
    logic fv, st, fl; logic [31:0] fpc;
    logic ue, ut; logic [31:0] upc, uaddr;
  } vec_t;
  typedef struct packed { logic v; logic [31:0] pc; logic t; logic [31:0] a; } exp_t;
  exp_t sb[$];

  // Reference model state
  bit          m_v   [BTB];
  int unsigned m_tag [BTB];
  logic [31:0] m_tgt [BTB];
  int          m_cnt [PHT];
  int unsigned m_ghr;
  logic        ov, otk;
  logic [31:0] opc, oad;

  function automatic vec_t F(input logic [31:0] pc);
    vec_t v = '0; v.fv = 1'b1; v.fpc = pc; return v;
  endfunction
  function automatic vec_t U(input logic [31:0] pc, input logic t, input logic [31:0] a);
    vec_t v = '0; v.ue = 1'b1; v.upc = pc; v.ut = t; v.uaddr = a; v.fpc = 32'h1C000FF0; return v;
  endfunction
  function automatic int unsigned m_pidx(input logic [31:0] pc);
    int unsigned i = (pc >> 2) % PHT;
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  task automatic m_reset();
    foreach (m_v[i]) m_v[i] = 0;
    foreach (m_cnt[i]) m_cnt[i] = 1;
    m_ghr = 0; ov = 0; otk = 0; opc = '0; oad = '0;
  endtask

  task automatic step(input vec_t v);
    int unsigned b, p;
    logic hit, tk;
    logic [31:0] ad;
    exp_t e;
    @(negedge clk);
    fetch_valid = v.fv; fetch_stall = v.st; fetch_flush = v.fl; fetch_pc = v.fpc;
    update_en = v.ue; update_pc = v.upc; taken_or_not_actual = v.ut; branch_actual_addr = v.uaddr;
    b   = (v.fpc >> 2) % BTB;
    p   = m_pidx(v.fpc);
    hit = m_v[b] && (m_tag[b] == (v.fpc >> (2 + IW)) % (1 << TW));
    tk  = hit && (m_cnt[p] >= 2);
    ad  = tk ? m_tgt[b] : v.fpc + 32'd4;
    if (v.fl) ov = 1'b0;
    else if (!v.st) begin ov = v.fv; opc = v.fpc; otk = tk; oad = ad; end
    e.v = ov; e.pc = opc; e.t = otk; e.a = oad;
    sb.push_back(e);
    if (v.ue) begin
      p = m_pidx(v.upc);
      b = (v.upc >> 2) % BTB;
      if (v.ut) m_cnt[p] = (m_cnt[p] == 3) ? 3 : m_cnt[p] + 1;
      else      m_cnt[p] = (m_cnt[p] == 0) ? 0 : m_cnt[p] - 1;
      if (v.ut) begin
        m_v[b] = 1; m_tag[b] = (v.upc >> (2 + IW)) % (1 << TW); m_tgt[b] = v.uaddr;
      end
`ifdef BP_GSHARE_EN
      m_ghr = ((m_ghr << 1) | v.ut) % PHT;
`endif
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    update_en = 1'b0; fetch_valid = 1'b0; fetch_stall = 1'b0; fetch_flush = 1'b0;
    m_reset();
    #1;
    n_vec++;
    if ({pre_valid, pre_pc, pre_is_branch_taken, pre_branch_addr} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b pc=%h t=%b a=%h want all zero",
               pre_valid, pre_pc, pre_is_branch_taken, pre_branch_addr);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    vec_t vs[$];
    vec_t v;
    exp_t e;
    vs.push_back(F(32'h1C000000));
    vs.push_back(U(32'h1C000010, 1, 32'h1C000100));
    vs.push_back(F(32'h1C000010));
    vs.push_back(U(32'h1C000010, 0, 32'h1C000018));
    vs.push_back(U(32'h1C000010, 0, 32'h1C000018));
    vs.push_back(F(32'h1C000010));
    vs.push_back(U(32'h1C000010, 0, 32'h1C000018));
    vs.push_back(F(32'h1C000010));
    for (int k = 0; k < 4; k++) begin
      vs.push_back(U(32'h1C000010, 1, 32'h1C000100));
      vs.push_back(F(32'h1C000010));
    end
    for (int k = 0; k < 2; k++) begin
      vs.push_back(U(32'h1C000010, 0, 32'h1C000018));
      vs.push_back(F(32'h1C000010));
    end
    vs.push_back(U(32'h1C000010, 1, 32'h1C000100));
    vs.push_back(U(32'h1C000090, 1, 32'h1C000200));
    vs.push_back(F(32'h1C000010));
    vs.push_back(F(32'h1C000090));
    foreach (vs[i]) begin
      v = vs[i];
      step(v);
      e = sb.pop_front();
      n_vec++;
      if (pre_valid !== e.v || (e.v && {pre_pc, pre_is_branch_taken, pre_branch_addr} !== {e.pc, e.t, e.a})) begin
        n_err++;
        $display("FAIL basic[%0d] got v=%b pc=%h t=%b a=%h want v=%b pc=%h t=%b a=%h", i,
                 pre_valid, pre_pc, pre_is_branch_taken, pre_branch_addr, e.v, e.pc, e.t, e.a);
      end
      if (i == 0) begin
        n_vec++;
        if ({pre_valid, pre_pc, pre_is_branch_taken, pre_branch_addr} !== {1'b1, 32'h1C000000, 1'b0, 32'h1C000004}) begin
          n_err++;
          $display("FAIL first_fetch got v=%b pc=%h t=%b a=%h want v=1 pc=1c000000 t=0 a=1c000004",
                   pre_valid, pre_pc, pre_is_branch_taken, pre_branch_addr);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    vec_t vs[$];
    vec_t v;
    exp_t e;
    v = U(32'h1C000020, 1, 32'h1C000300); v.fv = 1; v.fpc = 32'h1C000020; vs.push_back(v);
    vs.push_back(F(32'h1C000020));
    v = U(32'h1C000020, 1, 32'h1C000340); v.fv = 1; v.fpc = 32'h1C000020; vs.push_back(v);
    vs.push_back(F(32'h1C000020));
    foreach (vs[i]) begin
      step(vs[i]);
      e = sb.pop_front();
      n_vec++;
      if (pre_valid !== e.v || (e.v && {pre_pc, pre_is_branch_taken, pre_branch_addr} !== {e.pc, e.t, e.a})) begin
        n_err++;
        $display("FAIL same_cycle[%0d] got v=%b t=%b a=%h want v=%b t=%b a=%h", i,
                 pre_valid, pre_is_branch_taken, pre_branch_addr, e.v, e.t, e.a);
      end
    end
  endtask

  task automatic test_stall_flush();
    vec_t vs[$];
    vec_t v;
    exp_t e;
    vs.push_back(F(32'h1C000020));
    for (int k = 0; k < 3; k++) begin
      v = F(32'h1C000400 + 4 * k); v.st = 1; v.fv = k[0]; vs.push_back(v);
    end
    v = F(32'h1C000500); v.st = 1; v.fl = 1; vs.push_back(v);
    v = F(32'h1C000504); v.st = 1; vs.push_back(v);
    v = F(32'h1C000508); v.fl = 1; vs.push_back(v);
    vs.push_back(F(32'h1C000020));
    foreach (vs[i]) begin
      step(vs[i]);
      e = sb.pop_front();
      n_vec++;
      if (pre_valid !== e.v || (e.v && {pre_pc, pre_is_branch_taken, pre_branch_addr} !== {e.pc, e.t, e.a})) begin
        n_err++;
        $display("FAIL stall_flush[%0d] got v=%b pc=%h t=%b a=%h want v=%b pc=%h t=%b a=%h", i,
                 pre_valid, pre_pc, pre_is_branch_taken, pre_branch_addr, e.v, e.pc, e.t, e.a);
      end
    end
  endtask

  // Starts from reset so the history is known: two taken updates leave GHR low bits = 11.
  task automatic test_gshare();
    vec_t vs[$];
    exp_t e;
    logic want_tk;
    test_reset();
    vs.push_back(U(32'h1C000040, 1, 32'h1C000700));
    vs.push_back(U(32'h1C000040, 1, 32'h1C000700));
    vs.push_back(F(32'h1C000040));
`ifdef BP_GSHARE_EN
    want_tk = 1'b0;
`else
    want_tk = 1'b1;
`endif
    foreach (vs[i]) begin
      step(vs[i]);
      e = sb.pop_front();
      n_vec++;
      if (pre_valid !== e.v || (e.v && {pre_pc, pre_is_branch_taken, pre_branch_addr} !== {e.pc, e.t, e.a})) begin
        n_err++;
        $display("FAIL gshare[%0d] got v=%b t=%b a=%h want v=%b t=%b a=%h", i,
                 pre_valid, pre_is_branch_taken, pre_branch_addr, e.v, e.t, e.a);
      end
    end
    n_vec++;
    if (pre_is_branch_taken !== want_tk) begin
      n_err++;
      $display("FAIL gshare_divergence got t=%b want t=%b", pre_is_branch_taken, want_tk);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v;
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      v = '0;
      v.fv    = ($urandom_range(0, 3) != 0);
      v.st    = ($urandom_range(0, 7) == 0);
      v.fl    = ($urandom_range(0, 11) == 0);
      v.fpc   = 32'h1C000000 + 4 * $urandom_range(0, 3) + 128 * $urandom_range(0, 1);
      v.ue    = ($urandom_range(0, 1) == 1);
      v.ut    = ($urandom_range(0, 2) != 0);
      v.upc   = 32'h1C000000 + 4 * $urandom_range(0, 3) + 128 * $urandom_range(0, 1);
      v.uaddr = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      step(v);
      e = sb.pop_front();
      n_vec++;
      if (pre_valid !== e.v || (e.v && {pre_pc, pre_is_branch_taken, pre_branch_addr} !== {e.pc, e.t, e.a})) begin
        n_err++;
        $display("FAIL back_to_back[%0d] got v=%b pc=%h t=%b a=%h want v=%b pc=%h t=%b a=%h", i,
                 pre_valid, pre_pc, pre_is_branch_taken, pre_branch_addr, e.v, e.pc, e.t, e.a);
      end
    end
  endtask

  task automatic test_reset_clears_tables();
    exp_t e;
    step(U(32'h1C000060, 1, 32'h1C000800));
    e = sb.pop_front();
    step(U(32'h1C000060, 1, 32'h1C000800));
    e = sb.pop_front();
    test_reset();
    step(F(32'h1C000060));
    e = sb.pop_front();
    n_vec++;
    if ({pre_valid, pre_is_branch_taken, pre_branch_addr} !== {e.v, e.t, e.a} ||
        {pre_is_branch_taken, pre_branch_addr} !== {1'b0, 32'h1C000064}) begin
      n_err++;
      $display("FAIL reset_clears_tables got v=%b t=%b a=%h want v=1 t=0 a=1c000064",
               pre_valid, pre_is_branch_taken, pre_branch_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_stall_flush();
    test_gshare();
    test_back_to_back();
    test_reset_clears_tables();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
